// File: rtl/apb_timer_mc_pkg.sv
// Shared register map, CFG bit positions and decode enums for the multi-channel APB timer.
package apb_timer_mc_pkg;

    localparam int unsigned CH_STRIDE = 32'h10;
    localparam int unsigned GLB_BASE  = 32'h100;

    // Enum values are the register byte offset divided by 4.
    typedef enum logic [1:0] {
        REG_CFG    = 2'd0,
        REG_VAL    = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } ch_reg_e;

    typedef enum logic [1:0] {
        GREG_START      = 2'd0,
        GREG_STOP       = 2'd1,
        GREG_RESET      = 2'd2,
        GREG_IRQ_STATUS = 2'd3
    } glb_reg_e;

    localparam int unsigned CFG_ENABLE   = 0;
    localparam int unsigned CFG_RESET    = 1;
    localparam int unsigned CFG_IRQ_EN   = 2;
    localparam int unsigned CFG_CMP_CLR  = 4;
    localparam int unsigned CFG_ONE_SHOT = 5;
    localparam int unsigned CFG_PRESC_EN = 6;
    localparam int unsigned CFG_REF_EN   = 7;
    localparam int unsigned PRESC_LSB    = 8;
    localparam int unsigned PRESC_MSB    = 15;
    localparam int unsigned CFG_CASCADE  = 31;

endpackage

// File: rtl/apb_timer_channel.sv
// One timer channel: up-counter with compare, 8-bit prescaler, pending flag and cascade carry.
module apb_timer_channel
    import apb_timer_mc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter bit          CASCADE_OK = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ref_tick_i,
    input  logic                 carry_in,
    input  logic                 cfg_we_i,
    input  logic                 val_we_i,
    input  logic                 cmp_we_i,
    input  logic                 status_we_i,
    input  logic [31:0]          wdata_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 reset_i,
    output logic [31:0]          cfg_o,
    output logic [CNT_WIDTH-1:0] val_o,
    output logic [CNT_WIDTH-1:0] cmp_o,
    output logic                 pending_o,
    output logic                 irq_o,
    output logic                 carry_out
);

    logic                 enable_q, enable_d, irq_en_q, irq_en_d, cmp_clr_q, cmp_clr_d;
    logic                 one_shot_q, one_shot_d, presc_en_q, presc_en_d, ref_en_q, ref_en_d;
    logic                 cascade_q, cascade_d, pending_q, pending_d;
    logic [7:0]           presc_val_q, presc_val_d, presc_cnt_q, presc_cnt_d;
    logic [CNT_WIDTH-1:0] val_q, val_d, cmp_q, cmp_d;
    logic                 src, tick, hit, clr;
    logic                 unused_wdata;

    assign unused_wdata = ^{wdata_i[3], wdata_i[30:16]};

    always_comb begin
        src         = ref_en_q ? ref_tick_i : 1'b1;
        tick        = 1'b0;
        presc_cnt_d = presc_cnt_q;
        if (cascade_q) begin
            tick = enable_q & carry_in;
        end else if (enable_q && src) begin
            if (!presc_en_q) begin
                tick = 1'b1;
            end else if (presc_cnt_q == presc_val_q) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + 8'd1;
            end
        end

        hit   = tick && (val_q == cmp_q);
        val_d = val_q;
        if (tick) val_d = (hit && cmp_clr_q) ? '0 : val_q + CNT_WIDTH'(1);

        // Write/reset priority over the tick: RESET beats increment, VAL write beats both.
        clr = reset_i | (cfg_we_i & wdata_i[CFG_RESET]);
        if (clr) begin
            val_d       = '0;
            presc_cnt_d = '0;
        end
        if (val_we_i) val_d = wdata_i[CNT_WIDTH-1:0];

        cmp_d     = cmp_we_i ? wdata_i[CNT_WIDTH-1:0] : cmp_q;
        pending_d = (pending_q & ~(status_we_i & wdata_i[0])) | hit;

        enable_d = enable_q;
        if (hit && one_shot_q) enable_d = 1'b0;
        if (cfg_we_i)          enable_d = wdata_i[CFG_ENABLE];
        if (start_i)           enable_d = 1'b1;
        if (stop_i)            enable_d = 1'b0;

        irq_en_d    = cfg_we_i ? wdata_i[CFG_IRQ_EN]            : irq_en_q;
        cmp_clr_d   = cfg_we_i ? wdata_i[CFG_CMP_CLR]           : cmp_clr_q;
        one_shot_d  = cfg_we_i ? wdata_i[CFG_ONE_SHOT]          : one_shot_q;
        presc_en_d  = cfg_we_i ? wdata_i[CFG_PRESC_EN]          : presc_en_q;
        ref_en_d    = cfg_we_i ? wdata_i[CFG_REF_EN]            : ref_en_q;
        presc_val_d = cfg_we_i ? wdata_i[PRESC_MSB:PRESC_LSB]   : presc_val_q;
        cascade_d   = cfg_we_i ? (CASCADE_OK & wdata_i[CFG_CASCADE]) : cascade_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            cmp_clr_q   <= 1'b0;
            one_shot_q  <= 1'b0;
            presc_en_q  <= 1'b0;
            ref_en_q    <= 1'b0;
            cascade_q   <= 1'b0;
            pending_q   <= 1'b0;
            presc_val_q <= '0;
            presc_cnt_q <= '0;
            val_q       <= '0;
            cmp_q       <= '0;
        end else begin
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            cmp_clr_q   <= cmp_clr_d;
            one_shot_q  <= one_shot_d;
            presc_en_q  <= presc_en_d;
            ref_en_q    <= ref_en_d;
            cascade_q   <= cascade_d;
            pending_q   <= pending_d;
            presc_val_q <= presc_val_d;
            presc_cnt_q <= presc_cnt_d;
            val_q       <= val_d;
            cmp_q       <= cmp_d;
        end
    end

    always_comb begin
        cfg_o                        = '0;
        cfg_o[CFG_ENABLE]            = enable_q;
        cfg_o[CFG_IRQ_EN]            = irq_en_q;
        cfg_o[CFG_CMP_CLR]           = cmp_clr_q;
        cfg_o[CFG_ONE_SHOT]          = one_shot_q;
        cfg_o[CFG_PRESC_EN]          = presc_en_q;
        cfg_o[CFG_REF_EN]            = ref_en_q;
        cfg_o[PRESC_MSB:PRESC_LSB]   = presc_val_q;
        cfg_o[CFG_CASCADE]           = cascade_q;
    end

    assign val_o     = val_q;
    assign cmp_o     = cmp_q;
    assign pending_o = pending_q;
    assign irq_o     = pending_q & irq_en_q;
    assign carry_out = tick & (val_q == '1);

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer top: APB decode, read mux, global START/STOP/RESET fan-out, cascade wiring.
module apb_timer_mc
    import apb_timer_mc_pkg::*;
#(
    parameter int unsigned NB_CH          = 4,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      ref_tick_i,
    output logic [NB_CH-1:0]          irq_o
);

    logic [31:0]          addr, ch_num, rdata;
    logic                 ch_hit, glb_hit, access, wr_en;
    ch_reg_e              ch_reg;
    glb_reg_e             glb_reg;
    logic [NB_CH-1:0]     start_v, stop_v, reset_v, pending, carry, carry_in;
    logic [31:0]          cfg_rd [NB_CH];
    logic [CNT_WIDTH-1:0] val_rd [NB_CH];
    logic [CNT_WIDTH-1:0] cmp_rd [NB_CH];
    logic                 unused_carry;

    assign addr    = 32'(PADDR);
    assign ch_num  = addr / CH_STRIDE;
    assign ch_hit  = (addr < GLB_BASE) && (ch_num < NB_CH);
    assign glb_hit = (addr >= GLB_BASE) && (addr < GLB_BASE + CH_STRIDE);
    assign ch_reg  = ch_reg_e'(addr[3:2]);
    assign glb_reg = glb_reg_e'(addr[3:2]);
    assign access  = PSEL & PENABLE;
    assign wr_en   = access & PWRITE & (ch_hit | glb_hit);

    assign start_v = (wr_en && glb_hit && glb_reg == GREG_START) ? PWDATA[NB_CH-1:0] : '0;
    assign stop_v  = (wr_en && glb_hit && glb_reg == GREG_STOP)  ? PWDATA[NB_CH-1:0] : '0;
    assign reset_v = (wr_en && glb_hit && glb_reg == GREG_RESET) ? PWDATA[NB_CH-1:0] : '0;
    assign unused_carry = ^carry;

    for (genvar n = 0; n < NB_CH; n++) begin : g_ch
        logic sel;
        assign sel = wr_en && ch_hit && (ch_num == n);

        // Only odd channels may chain onto their even neighbour.
        if (n % 2 == 1) begin : g_casc
            assign carry_in[n] = carry[n-1];
        end else begin : g_nocasc
            assign carry_in[n] = 1'b0;
        end

        apb_timer_channel #(
            .CNT_WIDTH  (CNT_WIDTH),
            .CASCADE_OK (n % 2 == 1)
        ) u_ch (
            .clk_i       (HCLK),
            .rst_ni      (HRESETn),
            .ref_tick_i  (ref_tick_i),
            .carry_in    (carry_in[n]),
            .cfg_we_i    (sel && ch_reg == REG_CFG),
            .val_we_i    (sel && ch_reg == REG_VAL),
            .cmp_we_i    (sel && ch_reg == REG_CMP),
            .status_we_i (sel && ch_reg == REG_STATUS),
            .wdata_i     (PWDATA),
            .start_i     (start_v[n]),
            .stop_i      (stop_v[n]),
            .reset_i     (reset_v[n]),
            .cfg_o       (cfg_rd[n]),
            .val_o       (val_rd[n]),
            .cmp_o       (cmp_rd[n]),
            .pending_o   (pending[n]),
            .irq_o       (irq_o[n]),
            .carry_out   (carry[n])
        );
    end

    always_comb begin
        rdata = '0;
        if (ch_hit) begin
            for (int unsigned i = 0; i < NB_CH; i++) begin
                if (ch_num == i) begin
                    case (ch_reg)
                        REG_CFG:    rdata = cfg_rd[i];
                        REG_VAL:    rdata = 32'(val_rd[i]);
                        REG_CMP:    rdata = 32'(cmp_rd[i]);
                        REG_STATUS: rdata = {31'd0, pending[i]};
                        default:    rdata = '0;
                    endcase
                end
            end
        end else if (glb_hit && glb_reg == GREG_IRQ_STATUS) begin
            rdata = 32'(pending);
        end
    end

    assign PRDATA  = (access && (ch_hit || glb_hit)) ? rdata : '0;
    assign PSLVERR = access & ~(ch_hit | glb_hit);
    assign PREADY  = 1'b1;

endmodule

// File: tb/tb_apb_timer_mc.sv
// Self-checking bench for apb_timer_mc against a cycle-level behavioural model of the register map.
module tb_apb_timer_mc;
    localparam int NB = 4;
    localparam int CW = 32;
    localparam int AW = 12;
    localparam longint unsigned VMAX = (64'd1 << CW) - 1;

    logic          HCLK = 1'b0, HRESETn = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, ref_tick_i = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic [NB-1:0] irq_o;

    apb_timer_mc #(.NB_CH(NB), .CNT_WIDTH(CW), .APB_ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .ref_tick_i(ref_tick_i), .irq_o(irq_o)
    );

    always #5 HCLK = ~HCLK;

    int compared = 0, mismatched = 0;
    int ref_period = 0;
    bit ref_manual = 1'b0;
    int cyc = 0;

    // Reference model state, one entry per channel
    bit m_en[NB], m_ie[NB], m_cc[NB], m_os[NB], m_pe[NB], m_re[NB], m_ca[NB], m_pend[NB];
    int unsigned m_pv[NB], m_pc[NB];
    longint unsigned m_val[NB], m_cmp[NB];

    function automatic void model_step();
        bit tk[NB], hitv[NB];
        bit n_en[NB], n_ie[NB], n_cc[NB], n_os[NB], n_pe[NB], n_re[NB], n_ca[NB], n_pend[NB];
        int unsigned n_pv[NB], n_pc[NB], a, ch;
        longint unsigned n_val[NB], n_cmp[NB];
        logic [31:0] d;
        n_en = m_en; n_ie = m_ie; n_cc = m_cc; n_os = m_os; n_pe = m_pe; n_re = m_re;
        n_ca = m_ca; n_pend = m_pend; n_pv = m_pv; n_pc = m_pc; n_val = m_val; n_cmp = m_cmp;
        for (int n = 0; n < NB; n++) begin
            bit src;
            src = m_re[n] ? ref_tick_i : 1'b1;
            tk[n] = 1'b0;
            hitv[n] = 1'b0;
            if (n % 2 == 1 && m_ca[n]) begin
                tk[n] = m_en[n] && tk[n-1] && (m_val[n-1] == VMAX);
            end else if (m_en[n] && src) begin
                if (!m_pe[n]) tk[n] = 1'b1;
                else if (m_pc[n] == m_pv[n]) begin tk[n] = 1'b1; n_pc[n] = 0; end
                else n_pc[n] = (m_pc[n] + 1) % 256;
            end
            if (tk[n]) begin
                if (m_val[n] == m_cmp[n]) begin
                    hitv[n] = 1'b1;
                    n_pend[n] = 1'b1;
                    if (m_os[n]) n_en[n] = 1'b0;
                    n_val[n] = m_cc[n] ? 0 : (m_val[n] + 1) & VMAX;
                end else begin
                    n_val[n] = (m_val[n] + 1) & VMAX;
                end
            end
        end
        if (PSEL && PENABLE && PWRITE) begin
            a = PADDR;
            d = PWDATA;
            if (a < 256 && a / 16 < NB) begin
                ch = a / 16;
                case ((a % 16) / 4)
                    0: begin
                        n_en[ch] = d[0]; n_ie[ch] = d[2]; n_cc[ch] = d[4]; n_os[ch] = d[5];
                        n_pe[ch] = d[6]; n_re[ch] = d[7]; n_pv[ch] = (d >> 8) & 32'hFF;
                        n_ca[ch] = (ch % 2 == 1) && d[31];
                        if (d[1]) begin n_val[ch] = 0; n_pc[ch] = 0; end
                    end
                    1: n_val[ch] = d & VMAX;
                    2: n_cmp[ch] = d & VMAX;
                    default: if (d[0]) n_pend[ch] = hitv[ch];
                endcase
            end else if (a >= 256 && a < 272) begin
                for (int n = 0; n < NB; n++) begin
                    if (d[n]) begin
                        case ((a - 256) / 4)
                            0: n_en[n] = 1'b1;
                            1: n_en[n] = 1'b0;
                            2: begin n_val[n] = 0; n_pc[n] = 0; end
                            default: ;
                        endcase
                    end
                end
            end
        end
        if (!HRESETn) begin
            for (int n = 0; n < NB; n++) begin
                n_en[n] = 0; n_ie[n] = 0; n_cc[n] = 0; n_os[n] = 0; n_pe[n] = 0; n_re[n] = 0;
                n_ca[n] = 0; n_pend[n] = 0; n_pv[n] = 0; n_pc[n] = 0; n_val[n] = 0; n_cmp[n] = 0;
            end
        end
        m_en = n_en; m_ie = n_ie; m_cc = n_cc; m_os = n_os; m_pe = n_pe; m_re = n_re;
        m_ca = n_ca; m_pend = n_pend; m_pv = n_pv; m_pc = n_pc; m_val = n_val; m_cmp = n_cmp;
    endfunction

    function automatic logic [32:0] model_read(int unsigned a);
        int unsigned c;
        logic [31:0] r;
        if (a < 256 && a / 16 < NB) begin
            c = a / 16;
            case ((a % 16) / 4)
                0: r = {m_ca[c], 15'd0, 8'(m_pv[c]), m_re[c], m_pe[c], m_os[c], m_cc[c],
                        1'b0, m_ie[c], 1'b0, m_en[c]};
                1: r = 32'(m_val[c]);
                2: r = 32'(m_cmp[c]);
                default: r = {31'd0, m_pend[c]};
            endcase
            return {1'b0, r};
        end
        if (a >= 256 && a < 272) begin
            r = '0;
            if ((a - 256) / 4 == 3) for (int n = 0; n < NB; n++) r[n] = m_pend[n];
            return {1'b0, r};
        end
        return {1'b1, 32'd0};
    endfunction

    function automatic logic [NB-1:0] model_irq();
        logic [NB-1:0] v;
        for (int n = 0; n < NB; n++) v[n] = m_pend[n] & m_ie[n];
        return v;
    endfunction

    task automatic do_cycle();
        if (ref_period > 0)      ref_tick_i = (cyc % ref_period == ref_period - 1);
        else if (ref_period < 0) ref_tick_i = 1'($urandom_range(0, 1));
        else                     ref_tick_i = ref_manual;
        model_step();
        @(posedge HCLK);
        cyc++;
        @(negedge HCLK);
    endtask

    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        do_cycle();
        PENABLE = 1'b1;
        do_cycle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] got, output logic got_err,
                            output logic [31:0] exp, output logic exp_err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        do_cycle();
        PENABLE = 1'b1;
        #1;
        got = PRDATA;
        got_err = PSLVERR;
        {exp_err, exp} = model_read(32'(a));
        do_cycle();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] got, exp;
    logic        gerr, eerr;

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (3) do_cycle();
        compared++; if (irq_o !== '0) begin mismatched++; $display("FAIL reset_irq got=%h exp=0", irq_o); end
        compared++; if (PRDATA !== '0) begin mismatched++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
        compared++; if (PSLVERR !== 1'b0) begin mismatched++; $display("FAIL reset_pslverr got=%b exp=0", PSLVERR); end
        HRESETn = 1'b1;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_read(AW'(c * 16 + r * 4), got, gerr, exp, eerr);
                compared++;
                if (got !== 32'd0 || got !== exp || gerr !== 1'b0) begin
                    mismatched++;
                    $display("FAIL reset_reg ch%0d r%0d got=%h err=%b exp=%h err=0", c, r, got, gerr, exp);
                end
            end
        end
    endtask

    task automatic test_compare_irq();
        apb_write(12'h008, 32'd5);
        apb_write(12'h000, 32'h1);
        repeat (8) do_cycle();
        apb_read(12'h004, got, gerr, exp, eerr);
        compared++; if (got !== exp) begin mismatched++; $display("FAIL ch0_val got=%h exp=%h", got, exp); end
        apb_read(12'h00C, got, gerr, exp, eerr);
        compared++; if (got !== 32'd1 || got !== exp) begin mismatched++; $display("FAIL ch0_pending got=%h exp=1", got); end
        compared++; if (irq_o[0] !== 1'b0) begin mismatched++; $display("FAIL ch0_irq_masked got=%b exp=0", irq_o[0]); end
        apb_write(12'h000, 32'h5);
        compared++; if (irq_o[0] !== 1'b1 || irq_o !== model_irq()) begin mismatched++; $display("FAIL ch0_irq_en got=%h exp=%h", irq_o, model_irq()); end
        apb_write(12'h00C, 32'h1);
        compared++; if (irq_o[0] !== 1'b0) begin mismatched++; $display("FAIL ch0_irq_clr got=%b exp=0", irq_o[0]); end
        apb_read(12'h00C, got, gerr, exp, eerr);
        compared++; if (got !== 32'd0 || got !== exp) begin mismatched++; $display("FAIL ch0_status_clr got=%h exp=0", got); end
        apb_write(12'h104, 32'h1);
    endtask

    task automatic test_prescaler();
        apb_write(12'h018, 32'd2);
        apb_write(12'h010, 32'h0000_0351);
        for (int i = 0; i < 12; i++) begin
            apb_read(12'h014, got, gerr, exp, eerr);
            compared++;
            if (got !== exp || got > 32'd2) begin mismatched++; $display("FAIL ch1_presc_val i=%0d got=%h exp=%h", i, got, exp); end
        end
        apb_read(12'h010, got, gerr, exp, eerr);
        compared++; if (got !== 32'h351 || got !== exp) begin mismatched++; $display("FAIL ch1_cfg got=%h exp=351", got); end
        apb_read(12'h01C, got, gerr, exp, eerr);
        compared++; if (got !== exp) begin mismatched++; $display("FAIL ch1_pending got=%h exp=%h", got, exp); end
        apb_write(12'h010, 32'h0);
    endtask

    task automatic test_one_shot();
        apb_write(12'h028, 32'd3);
        apb_write(12'h020, 32'h0000_00A1);
        ref_period = 7;
        repeat (60) do_cycle();
        apb_read(12'h024, got, gerr, exp, eerr);
        compared++; if (got !== 32'd4 || got !== exp) begin mismatched++; $display("FAIL ch2_oneshot_val got=%h exp=4", got); end
        apb_read(12'h020, got, gerr, exp, eerr);
        compared++; if (got !== 32'hA0 || got !== exp) begin mismatched++; $display("FAIL ch2_oneshot_cfg got=%h exp=a0", got); end
        ref_period = 0;
    endtask

    task automatic test_cascade();
        apb_write(12'h104, 32'hF);
        apb_write(12'h108, 32'hF);
        apb_write(12'h010, 32'h8000_0001);
        apb_write(12'h004, 32'hFFFF_FFFE);
        apb_write(12'h000, 32'h81);
        for (int k = 0; k < 2; k++) begin
            ref_manual = 1'b1; do_cycle();
            ref_manual = 1'b0; do_cycle();
        end
        apb_read(12'h004, got, gerr, exp, eerr);
        compared++; if (got !== 32'd0 || got !== exp) begin mismatched++; $display("FAIL casc_ch0 got=%h exp=0", got); end
        apb_read(12'h014, got, gerr, exp, eerr);
        compared++; if (got !== 32'd1 || got !== exp) begin mismatched++; $display("FAIL casc_ch1 got=%h exp=1", got); end
        apb_read(12'h030, got, gerr, exp, eerr);
        compared++; if (got !== exp) begin mismatched++; $display("FAIL casc_ch3_cfg got=%h exp=%h", got, exp); end
        apb_write(12'h000, 32'h0);
        apb_write(12'h010, 32'h0);
    endtask

    task automatic test_global();
        logic [31:0] v1;
        apb_write(12'h020, 32'h0);
        apb_write(12'h108, 32'hF);
        apb_write(12'h100, 32'h5);
        repeat (5) do_cycle();
        for (int c = 0; c < 3; c++) begin
            apb_read(AW'(c * 16 + 4), got, gerr, exp, eerr);
            compared++;
            if (got !== exp || (c == 1 && got !== 32'd0) || (c != 1 && got == 32'd0)) begin
                mismatched++; $display("FAIL start_val ch%0d got=%h exp=%h", c, got, exp);
            end
        end
        apb_write(12'h104, 32'h1);
        apb_read(12'h004, v1, gerr, exp, eerr);
        repeat (4) do_cycle();
        apb_read(12'h004, got, gerr, exp, eerr);
        compared++; if (got !== v1 || got !== exp) begin mismatched++; $display("FAIL stop_ch0 got=%h exp=%h", got, v1); end
        apb_read(12'h024, got, gerr, exp, eerr);
        compared++; if (got !== exp) begin mismatched++; $display("FAIL stop_ch2_runs got=%h exp=%h", got, exp); end
    endtask

    task automatic test_val_write_tick();
        apb_write(12'h024, 32'h1234);
        apb_read(12'h024, got, gerr, exp, eerr);
        compared++; if (got !== 32'h1235 || got !== exp) begin mismatched++; $display("FAIL val_write_wins got=%h exp=1235", got); end
    endtask

    task automatic test_errors();
        apb_read(12'h0F0, got, gerr, exp, eerr);
        compared++; if (gerr !== 1'b1 || got !== 32'd0 || eerr !== 1'b1) begin mismatched++; $display("FAIL err_0f0 got=%h err=%b exp=0 err=1", got, gerr); end
        apb_read(12'h040, got, gerr, exp, eerr);
        compared++; if (gerr !== 1'b1 || got !== 32'd0) begin mismatched++; $display("FAIL err_ch4 got=%h err=%b exp=0 err=1", got, gerr); end
        apb_read(12'h110, got, gerr, exp, eerr);
        compared++; if (gerr !== 1'b1 || got !== 32'd0) begin mismatched++; $display("FAIL err_110 got=%h err=%b exp=0 err=1", got, gerr); end
        apb_write(12'h040, 32'h0000_00F5);
        apb_read(12'h000, got, gerr, exp, eerr);
        compared++; if (got !== exp || gerr !== 1'b0) begin mismatched++; $display("FAIL err_write_dropped got=%h exp=%h", got, exp); end
        apb_read(12'h10C, got, gerr, exp, eerr);
        compared++; if (got !== exp || gerr !== 1'b0) begin mismatched++; $display("FAIL irq_status got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        int unsigned op, ch, rg;
        logic [31:0] d;
        logic [AW-1:0] a;
        ref_period = -1;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, NB);
            rg = $urandom_range(0, 3);
            d = $urandom;
            if (rg == 0) d[15:8] = 8'($urandom_range(0, 3));
            else if (rg != 3) d = ($urandom_range(0, 3) == 0) ? 32'(VMAX - $urandom_range(0, 2)) : 32'($urandom_range(0, 12));
            a = ($urandom_range(0, 7) == 0) ? AW'(256 + 4 * rg) : AW'(ch * 16 + rg * 4);
            if (op < 2) begin
                repeat ($urandom_range(1, 6)) do_cycle();
            end else if (op < 6) begin
                apb_write(a, d);
            end else begin
                apb_read(a, got, gerr, exp, eerr);
                compared++;
                if (got !== exp || gerr !== eerr) begin
                    mismatched++; $display("FAIL rand_read a=%h got=%h err=%b exp=%h err=%b", a, got, gerr, exp, eerr);
                end
            end
            compared++;
            if (irq_o !== model_irq()) begin mismatched++; $display("FAIL rand_irq i=%0d got=%h exp=%h", i, irq_o, model_irq()); end
        end
        ref_period = 0;
    endtask

    task automatic test_reset_midcount();
        apb_write(12'h000, 32'h0000_0005);
        apb_write(12'h100, 32'hF);
        repeat (12) do_cycle();
        HRESETn = 1'b0;
        do_cycle();
        compared++; if (irq_o !== '0) begin mismatched++; $display("FAIL midreset_irq got=%h exp=0", irq_o); end
        compared++; if (PRDATA !== '0 || PSLVERR !== 1'b0) begin mismatched++; $display("FAIL midreset_bus got=%h/%b exp=0/0", PRDATA, PSLVERR); end
        HRESETn = 1'b1;
        for (int c = 0; c < NB; c++) begin
            apb_read(AW'(c * 16 + 4), got, gerr, exp, eerr);
            compared++; if (got !== 32'd0 || got !== exp) begin mismatched++; $display("FAIL midreset_val ch%0d got=%h exp=0", c, got); end
        end
    endtask

    initial begin
        @(negedge HCLK);
        test_reset();
        test_compare_irq();
        test_prescaler();
        test_one_shot();
        test_cascade();
        test_global();
        test_val_write_tick();
        test_errors();
        test_random();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
